display_interval_timer: RTL and testbench

Parametrised, run-time programmable interval timer for the reaction-timer display path. It replaces the fixed 5000-count display wait counter with a loadable limit, a tick prescaler, one-shot or auto-reload modes, pause via enable, abort, and explicit busy/expired status. It sits between the display control FSM, which drives start/enable/stop, and the display multiplex logic, which consumes done and q.

---
 rtl/display_interval_timer.sv | 99 +++++++++
 tb/tb_display_interval_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/display_interval_timer.sv
// Programmable interval timer for the reaction-timer display path: loadable
// limit, tick prescaler, one-shot or auto-reload, pause via enable, abort.
module display_interval_timer #(
  parameter int WIDTH         = 13,
  parameter int DEFAULT_LIMIT = 5000,
  parameter int PRESCALE      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] DEF_LIM  = WIDTH'(DEFAULT_LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lim_q     <= DEF_LIM;
      cnt_q     <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else if (start) begin
      // A terminal tick coinciding with start is dropped: restart wins.
      lim_d   = (limit == '0) ? DEF_LIM : limit;
      mode_d  = auto_reload;
      cnt_d   = '0;
      pre_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN && enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (cnt_q == lim_q - WIDTH'(1)) begin
          cnt_d  = '0;
          done_d = 1'b1;
          if (!mode_q) state_d = EXPIRED;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    busy_d    = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  assign q       = cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_display_interval_timer.sv
// Bench for display_interval_timer: done-pulse scoreboard keyed by cycle
// number, plus directed checks of q/busy/expired on two prescale settings.
module tb_display_interval_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, stop_a, enable_a, auto_a;
  logic [12:0] limit_a, q_a;
  logic        busy_a, done_a, expired_a;
  logic        start_b, stop_b, enable_b, auto_b;
  logic [12:0] limit_b, q_b;
  logic        busy_b, done_b, expired_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e;
  int qa[$];
  int qb[$];

  display_interval_timer #(.WIDTH(13), .DEFAULT_LIMIT(5000), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .enable(enable_a),
    .auto_reload(auto_a), .limit(limit_a), .q(q_a), .busy(busy_a), .done(done_a),
    .expired(expired_a)
  );

  display_interval_timer #(.WIDTH(13), .DEFAULT_LIMIT(5000), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .enable(enable_b),
    .auto_reload(auto_b), .limit(limit_b), .q(q_b), .busy(busy_b), .done(done_b),
    .expired(expired_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each done pulse must match the oldest expected cycle number.
  always @(negedge clk) begin
    if (reset && done_a) begin
      if (qa.size() == 0) chk("done_a_unexpected", 1, 0);
      else chk("done_a_cycle", cyc, qa.pop_front());
    end
    if (reset && done_b) begin
      if (qb.size() == 0) chk("done_b_unexpected", 1, 0);
      else chk("done_b_cycle", cyc, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    {start_a, stop_a, enable_a, auto_a} = '0;
    {start_b, stop_b, enable_b, auto_b} = '0;
    limit_a = '0;
    limit_b = '0;
    @(negedge clk);
    chk("rst_q_a", q_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_exp_a", expired_a, 0);
    chk("rst_q_b", q_b, 0);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b1;

    // Reset asserted mid-run clears outputs immediately.
    @(negedge clk);
    start_a = 1; limit_a = 10; enable_a = 1; e = cyc + 1; qa.push_back(e + 10);
    @(negedge clk);
    start_a = 0;
    repeat (3) @(negedge clk);
    chk("run_q", q_a, cyc - e);
    chk("run_busy", busy_a, 1);
    reset = 1'b0;
    #1;
    chk("midrst_q", q_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_exp", expired_a, 0);
    qa.delete();
    @(negedge clk);
    reset = 1'b1;

    // limit == 0 selects the default 5000-count interval.
    @(negedge clk);
    start_a = 1; limit_a = 0; auto_a = 0; e = cyc + 1; qa.push_back(e + 5000);
    @(negedge clk);
    start_a = 0; limit_a = 7;
    for (int i = 0; i < 5100 && !expired_a; i++) @(negedge clk);
    chk("dflt_exp", expired_a, 1);
    chk("dflt_exp_cycle", cyc, e + 5000);
    chk("dflt_busy", busy_a, 0);
    chk("dflt_q", q_a, 0);
    enable_a = 0;
    @(negedge clk);
    chk("exp_hold", expired_a, 1);
    enable_a = 1;

    // Periodic, limit 5, three enable-low cycles in the first interval.
    @(negedge clk);
    start_a = 1; limit_a = 5; auto_a = 1; e = cyc + 1;
    qa.push_back(e + 8); qa.push_back(e + 13); qa.push_back(e + 18);
    @(negedge clk);
    start_a = 0;
    @(negedge clk);
    chk("per_q1", q_a, 1);
    enable_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_q", q_a, 1);
    end
    enable_a = 1;
    while (cyc < e + 18) @(negedge clk);
    chk("per_busy", busy_a, 1);
    stop_a = 1; start_a = 1; limit_a = 3;
    @(negedge clk);
    stop_a = 0; start_a = 0;
    chk("stopstart_busy", busy_a, 0);
    chk("stopstart_q", q_a, 0);
    chk("stopstart_exp", expired_a, 0);
    repeat (6) @(negedge clk);
    chk("idle_busy", busy_a, 0);

    // Restart on the cycle of the terminal tick discards that done.
    start_a = 1; limit_a = 4; auto_a = 0; e = cyc + 1; qa.push_back(e + 4);
    @(negedge clk);
    start_a = 0;
    repeat (3) @(negedge clk);
    chk("rs_q3", q_a, 3);
    start_a = 1; qa.delete(); e = cyc + 1; qa.push_back(e + 4);
    @(negedge clk);
    start_a = 0;
    chk("rs_q", q_a, 0);
    chk("rs_done", done_a, 0);
    chk("rs_busy", busy_a, 1);
    for (int i = 0; i < 20 && !expired_a; i++) @(negedge clk);
    chk("rs_exp_cycle", cyc, e + 4);
    stop_a = 1;
    @(negedge clk);
    stop_a = 0;
    chk("stop_exp", expired_a, 0);
    chk("stop_busy", busy_a, 0);

    // limit 1 periodic: done every cycle, later limit changes ignored.
    start_a = 1; limit_a = 1; auto_a = 1; e = cyc + 1;
    for (int k = 1; k <= 8; k++) qa.push_back(e + k);
    @(negedge clk);
    start_a = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lim1_q", q_a, 0);
      if (i == 1) limit_a = 9;
    end
    stop_a = 1;
    @(negedge clk);
    stop_a = 0;
    chk("lim1_stop_busy", busy_a, 0);
    repeat (3) @(negedge clk);

    // Prescale 4, limit 3, one-shot.
    start_b = 1; limit_b = 3; enable_b = 1; auto_b = 0; e = cyc + 1; qb.push_back(e + 12);
    @(negedge clk);
    start_b = 0;
    for (int i = 0; i < 12; i++) begin
      chk("p4_q", q_b, i / 4);
      @(negedge clk);
    end
    chk("p4_exp", expired_b, 1);
    chk("p4_busy", busy_b, 0);
    chk("p4_q_end", q_b, 0);

    // Prescale 4 periodic with one enable-low cycle.
    start_b = 1; limit_b = 2; auto_b = 1; e = cyc + 1;
    qb.push_back(e + 9); qb.push_back(e + 17);
    @(negedge clk);
    start_b = 0;
    @(negedge clk);
    enable_b = 0;
    @(negedge clk);
    enable_b = 1;
    while (cyc < e + 17) @(negedge clk);
    stop_b = 1;
    @(negedge clk);
    stop_b = 0;
    chk("p4_stop_busy", busy_b, 0);
    repeat (3) @(negedge clk);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
